// File: rtl/s2p_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel receiver.
package s2p_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } s2p_state_t;

    localparam int S2P_DEFAULT_WIDTH = 4;

    // Bit counter must represent 0..width inclusive.
    function automatic int s2p_count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/s2p_hold_reg.sv
// Output holding register: presents completed words with valid/ready and
// raises a sticky overrun flag when a word completes while one is still held.
module s2p_hold_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] word,
    input  logic             complete,
    input  logic             ready_i,
    output logic [WIDTH-1:0] parallel_o,
    output logic             valid_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] parallel_q, parallel_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             consume;

    assign consume = valid_q & ready_i;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        parallel_d = parallel_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        if (complete && (!valid_q || consume)) begin
            parallel_d = word;
            valid_d    = 1'b1;
        end else if (complete) begin
            overrun_d  = 1'b1;
        end else if (consume) begin
            valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            parallel_q <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            parallel_q <= parallel_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign parallel_o = parallel_q;
    assign valid_o    = valid_q;
    assign overrun_o  = overrun_q;

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Collects a valid-qualified serial bit stream into WIDTH-bit words and hands
// each completed word to the output holding register.
module serial_to_parallel_rx
    import s2p_pkg::*;
#(
    parameter int WIDTH     = S2P_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic             serial_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] parallel_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             overrun_o
);

    localparam int            CW   = s2p_count_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    s2p_state_t       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             busy_q, busy_d;
    logic             complete;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        shift_d  = shift_q;
        complete = 1'b0;
        if (valid_i) begin
            if (MSB_FIRST) shift_d = {shift_q[WIDTH-2:0], serial_i};
            else           shift_d = {serial_i, shift_q[WIDTH-1:1]};
            // WIDTH >= 2, so the first accepted bit can never complete a word.
            if (state_q == IDLE) begin
                count_d = CW'(1);
                state_d = SHIFT;
            end else if (count_q == LAST) begin
                count_d  = '0;
                state_d  = IDLE;
                complete = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
        busy_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o = busy_q;

    // The completed word includes the bit accepted on this edge, hence shift_d.
    s2p_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk        (clk),
        .reset      (reset),
        .word       (shift_d),
        .complete   (complete),
        .ready_i    (ready_i),
        .parallel_o (parallel_o),
        .valid_o    (valid_o),
        .overrun_o  (overrun_o)
    );

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Bench for serial_to_parallel_rx: LSB-first and MSB-first instances share
// stimulus and are compared every cycle against a bit-list reference model.
module tb_serial_to_parallel_rx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset, valid_i, serial_i, ready_i;
    logic [W-1:0] par_l, par_m;
    logic         valid_l, valid_m, busy_l, busy_m, ovr_l, ovr_m;

    int checks   = 0;
    int failures = 0;

    // Reference model state: bits received so far and the held word.
    bit bits[$];
    bit m_valid, m_ovr;
    int m_word_l, m_word_m;

    always #5 clk = ~clk;

    serial_to_parallel_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .valid_i(valid_i), .serial_i(serial_i), .ready_i(ready_i),
        .parallel_o(par_l), .valid_o(valid_l), .busy_o(busy_l), .overrun_o(ovr_l)
    );

    serial_to_parallel_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .valid_i(valid_i), .serial_i(serial_i), .ready_i(ready_i),
        .parallel_o(par_m), .valid_o(valid_m), .busy_o(busy_m), .overrun_o(ovr_m)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit v, input bit s, input bit rdy, input bit rst);
        bit complete, consume;
        int wl, wm;
        if (rst) begin
            bits.delete();
            m_valid  = 1'b0;
            m_ovr    = 1'b0;
            m_word_l = 0;
            m_word_m = 0;
            return;
        end
        complete = 1'b0;
        consume  = m_valid && rdy;
        wl = 0;
        wm = 0;
        if (v) begin
            bits.push_back(s);
            if (bits.size() == W) begin
                for (int i = 0; i < W; i++) begin
                    wl += int'(bits[i]) << i;
                    wm += int'(bits[i]) << (W - 1 - i);
                end
                bits.delete();
                complete = 1'b1;
            end
        end
        if (complete && (!m_valid || consume)) begin
            m_word_l = wl;
            m_word_m = wm;
            m_valid  = 1'b1;
        end else if (complete) begin
            m_ovr = 1'b1;
        end else if (consume) begin
            m_valid = 1'b0;
        end
    endtask

    // Drive one cycle's inputs, let the edge happen, then compare on the falling edge.
    task automatic cycle(input bit v, input bit s, input bit rdy, input bit rst);
        reset    = rst;
        valid_i  = v;
        serial_i = s;
        ready_i  = rdy;
        @(posedge clk);
        model_edge(v, s, rdy, rst);
        @(negedge clk);
        check("lsb_parallel", 32'(par_l), 32'(m_word_l));
        check("msb_parallel", 32'(par_m), 32'(m_word_m));
        check("lsb_valid", 32'(valid_l), 32'(m_valid));
        check("msb_valid", 32'(valid_m), 32'(m_valid));
        check("lsb_busy", 32'(busy_l), 32'(bits.size() != 0));
        check("msb_busy", 32'(busy_m), 32'(bits.size() != 0));
        check("lsb_overrun", 32'(ovr_l), 32'(m_ovr));
        check("msb_overrun", 32'(ovr_m), 32'(m_ovr));
    endtask

    task automatic send_word(input logic [W-1:0] first_to_last, input bit rdy);
        for (int i = 0; i < W; i++) cycle(1'b1, first_to_last[i], rdy, 1'b0);
    endtask

    initial begin
        reset = 1'b1; valid_i = 1'b0; serial_i = 1'b0; ready_i = 1'b0;

        // Reset state
        cycle(0, 0, 0, 1);
        check("reset_parallel", 32'(par_l), 32'h0);
        check("reset_valid", 32'(valid_l), 32'h0);

        // Bits 1,0,1,1 with ready high
        cycle(1, 1, 1, 0);
        check("busy_after_bit1", 32'(busy_l), 32'h1);
        cycle(1, 0, 1, 0);
        cycle(1, 1, 1, 0);
        cycle(1, 1, 1, 0);
        check("word_d_lsb", 32'(par_l), 32'hD);
        check("word_b_msb", 32'(par_m), 32'hB);
        check("word_d_valid", 32'(valid_l), 32'h1);
        check("busy_low_on_complete", 32'(busy_l), 32'h0);
        cycle(0, 0, 1, 0);
        check("word_d_consumed", 32'(valid_l), 32'h0);

        // Bits 0,1, five idle cycles, then 1,1
        cycle(1, 0, 1, 0);
        cycle(1, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 1, 0);
            check("gap_busy", 32'(busy_l), 32'h1);
            check("gap_valid", 32'(valid_l), 32'h0);
        end
        cycle(1, 1, 1, 0);
        cycle(1, 1, 1, 0);
        check("gap_word_e", 32'(par_l), 32'hE);
        cycle(0, 0, 1, 0);

        // Overrun: 3 then C with ready low, consume, then a third word
        send_word(4'h3, 1'b0);
        send_word(4'hC, 1'b0);
        check("overrun_keeps_3", 32'(par_l), 32'h3);
        check("overrun_set", 32'(ovr_l), 32'h1);
        cycle(0, 0, 1, 0);
        check("overrun_consumed", 32'(valid_l), 32'h0);
        send_word(4'h5, 1'b0);
        check("third_word_5", 32'(par_l), 32'h5);
        check("overrun_sticky", 32'(ovr_l), 32'h1);

        // Simultaneous consume and completion
        cycle(0, 0, 0, 1);
        send_word(4'h5, 1'b0);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 1, 0);
        check("swap_word_a", 32'(par_l), 32'hA);
        check("swap_valid", 32'(valid_l), 32'h1);
        check("swap_no_overrun", 32'(ovr_l), 32'h0);

        // Reset mid-word discards partial bits
        cycle(0, 0, 1, 0);
        cycle(1, 0, 1, 0);
        cycle(1, 0, 1, 0);
        cycle(0, 0, 0, 1);
        check("midreset_busy", 32'(busy_l), 32'h0);
        check("midreset_parallel", 32'(par_l), 32'h0);
        send_word(4'hF, 1'b1);
        check("after_reset_word_f", 32'(par_l), 32'hF);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(9) < 7), $urandom_range(1), $urandom_range(1),
                  ($urandom_range(63) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel_rx.md
Name: serial_to_parallel_rx

Overview:
- Receive-side partner of the 4-bit parallel-to-serial shifter: collects a serial bit stream, qualified by a per-bit valid, into WIDTH-bit words.
- Presents each completed word on a held output register with a valid/ready handshake.
- Sits directly downstream of the serialiser; its valid_i/serial_i connect to the transmitter's valid_o/serial_o.
- Flags overrun when a word completes while the previous word is still unconsumed.

Parameters:
- WIDTH, 4, bits per word; legal range 2..32.
- MSB_FIRST, 0, bit order: 0 means first received bit lands in bit 0; 1 means first received bit lands in bit WIDTH-1.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- valid_i, input, 1, serial_i carries a valid bit this cycle.
- serial_i, input, 1, serial data bit.
- ready_i, input, 1, consumer accepts parallel_o this cycle when valid_o=1.
- parallel_o, output, WIDTH, assembled word; held stable while valid_o=1.
- valid_o, output, 1, parallel_o holds an unconsumed word.
- busy_o, output, 1, a partial word is in progress (bit count != 0).
- overrun_o, output, 1, sticky: a completed word was dropped.

Behaviour:
- Reset (synchronous, active-high, checked on clk rising edge): parallel_o=0, valid_o=0, busy_o=0, overrun_o=0, shift register=0, bit counter=0, FSM=IDLE.
- Reset mid-word discards the partial word and any held word.
- FSM states: IDLE (count=0) and SHIFT (0<count<WIDTH).
  - IDLE -> SHIFT on valid_i=1.
  - SHIFT -> IDLE when the WIDTH-th bit is accepted.
  - WIDTH=2 still passes through SHIFT for exactly one accepted bit.
- Bit acceptance: on each edge with valid_i=1:
  - Shift serial_i in (MSB_FIRST=0: shift right, insert at MSB so the first bit ends at bit 0; MSB_FIRST=1: shift left, insert at LSB).
  - Increment the counter.
- valid_i=0 gaps: counter and shift register hold, with no timeout; gaps of any length are legal mid-word.
- Word completion (the edge accepting bit WIDTH):
  - Counter wraps to 0.
  - The completed word, including this final bit, is the load candidate for the holding register on the same edge.
- Latency: parallel_o/valid_o update on the same edge that accepts the final bit, so they are visible the cycle after the final bit is presented.
- Holding register / handshake:
  - Consume: valid_o=1 and ready_i=1.
  - Load when (valid_o=0 or consume) and completion: parallel_o <= word, valid_o stays/becomes 1.
  - Consume without completion: valid_o <= 0; parallel_o keeps its last value.
  - Completion while valid_o=1 and ready_i=0: new word dropped, parallel_o unchanged, overrun_o <= 1 (sticky until reset).
  - Simultaneous consume and completion: new word loads, valid_o stays 1, no overrun.
- ready_i while valid_o=0 has no effect.
- busy_o = (counter != 0), registered; low on the completion edge.
- The counter is $clog2(WIDTH+1) bits wide, and arithmetic is unsigned.

Decomposition:
- Shared package s2p_pkg:
  - typedef enum {IDLE, SHIFT} s2p_state_t.
  - localparam S2P_DEFAULT_WIDTH=4.
  - function clog2-based count width.
- One natural sub-module: s2p_hold_reg, the output holding register with the valid/ready handshake and overrun detection. It takes word, complete and ready_i, and produces parallel_o, valid_o and overrun_o.
- The shift/count FSM stays in the top.

Test Plan:
- Reset, then valid_i=1 with bits 1,0,1,1 on consecutive cycles, ready_i=1 -> after the 4th edge parallel_o=4'hD, valid_o=1 for one cycle; busy_o high for cycles 1-3 only.
- MSB_FIRST=1 with the same bits 1,0,1,1 -> parallel_o=4'hB.
- Bits 0,1 then valid_i=0 for 5 cycles, then 1,1 -> parallel_o=4'hE; busy_o stays 1 through the gap; valid_o stays 0 until the 4th accepted bit.
- ready_i=0, two back-to-back words 4'h3 then 4'hC -> parallel_o stays 4'h3, valid_o=1, overrun_o=1 from the second completion onward; ready_i=1 then drops valid_o; a third word loads normally with overrun_o still 1.
- valid_o=1 holding 4'h5; ready_i=1 on the same edge another word 4'hA completes -> parallel_o=4'hA, valid_o stays 1, overrun_o stays 0.
- Two bits accepted, then reset=1 for one edge, then 4 bits 1,1,1,1 -> all outputs 0 after reset; next word is 4'hF (partial bits discarded).
